// File: rtl/ultrasonic_ranger.sv
// Ultrasonic sensor front end: fires the trigger pulse, times the echo and
// publishes the echo width as whole centimetres with a timeout flag.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1_900_000,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int MAX_CM         = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       echo,
    output logic       trig,
    output logic [4:0] distance,
    output logic       valid,
    output logic       timeout,
    output logic       busy
);

    localparam int TIMER_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int PERIOD_W  = $clog2(PERIOD_CYCLES + 1);
    localparam int SUB_W     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [TIMER_W-1:0]  TRIG_LAST    = TIMER_W'(TRIG_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST  = PERIOD_W'(PERIOD_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_SAT   = PERIOD_W'(PERIOD_CYCLES);
    localparam logic [SUB_W-1:0]    SUB_LAST     = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [4:0]          MAX_D        = 5'(MAX_CM);

    // The MEASURE entry cycle already has echo high, so it is counted as the first sample.
    localparam logic [SUB_W-1:0] SUB_FIRST = (CYCLES_PER_CM == 1) ? SUB_W'(0) : SUB_W'(1);
    localparam logic [4:0]       CM_FIRST  = (CYCLES_PER_CM == 1 && MAX_CM > 0) ? 5'd1 : 5'd0;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t               state;
    logic                 echo_meta;
    logic                 echo_s;
    logic                 echo_d;
    logic                 echo_rise;
    logic                 echo_fall;
    logic [TIMER_W-1:0]   timer;
    logic [PERIOD_W-1:0]  period_cnt;
    logic [SUB_W-1:0]     sub_cnt;
    logic [SUB_W-1:0]     sub_next;
    logic [4:0]           cm_cnt;
    logic [4:0]           cm_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    // cm counter saturates; the sub-counter keeps wrapping so the fraction stays meaningful.
    always_comb begin
        sub_next = sub_cnt;
        cm_next  = cm_cnt;
        if (sub_cnt == SUB_LAST) begin
            sub_next = '0;
            if (cm_cnt != MAX_D) cm_next = cm_cnt + 5'd1;
        end else begin
            sub_next = sub_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            period_cnt <= '0;
            sub_cnt    <= '0;
            cm_cnt     <= '0;
            trig       <= 1'b0;
            valid      <= 1'b0;
            distance   <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state != IDLE && period_cnt != PERIOD_SAT) period_cnt <= period_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= TRIG;
                        trig       <= 1'b1;
                        busy       <= 1'b1;
                        period_cnt <= '0;
                        timer      <= '0;
                    end
                end

                TRIG: begin
                    if (timer == TRIG_LAST) begin
                        state <= WAIT_RISE;
                        trig  <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT_RISE: begin
                    // Edge-based, so an echo already high on entry must fall and rise again.
                    if (echo_rise) begin
                        state   <= MEASURE;
                        sub_cnt <= SUB_FIRST;
                        cm_cnt  <= CM_FIRST;
                        timer   <= TIMER_W'(1);
                    end else if (timer == TIMEOUT_LAST) begin
                        state    <= HOLDOFF;
                        distance <= MAX_D;
                        timeout  <= 1'b1;
                        valid    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                MEASURE: begin
                    if (echo_fall) begin
                        state    <= HOLDOFF;
                        distance <= cm_cnt;
                        timeout  <= 1'b0;
                        valid    <= 1'b1;
                    end else if (echo_s) begin
                        if (timer == TIMEOUT_LAST) begin
                            state    <= HOLDOFF;
                            distance <= MAX_D;
                            timeout  <= 1'b1;
                            valid    <= 1'b1;
                        end else begin
                            timer   <= timer + 1'b1;
                            sub_cnt <= sub_next;
                            cm_cnt  <= cm_next;
                        end
                    end
                end

                HOLDOFF: begin
                    // period_cnt reaches PERIOD_CYCLES on this edge (or already has).
                    if (period_cnt >= PERIOD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    trig  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Front-end ranging stage for the ultrasonic sensor: generates the trigger pulse, times the echo pulse, and converts its width to an integer distance in centimetres. It sits directly upstream of the distance-to-Gray encoder and drives that stage's 5-bit `distance` input (0–30 cm). A `valid` strobe marks each new result, and a timeout flag marks echoes that are missing or out of range.

## Interface
- `TRIG_CYCLES`, 500: trigger high time in clocks (10 µs at 50 MHz).
- `CYCLES_PER_CM`, 2900: echo-high clocks per cm (58 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_900_000: maximum wait for the echo rise, and maximum echo-high time.
- `PERIOD_CYCLES`, 3_000_000: minimum spacing between trigger starts (60 ms sensor recovery).
- `MAX_CM`, 30: saturation value of `distance`. Must be ≤31.
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request one measurement. Sampled only in IDLE.
- `echo` in 1: raw sensor echo, asynchronous to `clk`.
- `trig` out 1: sensor trigger pulse.
- `distance` out 5: last measured distance in cm, range 0..MAX_CM. Held between results.
- `valid` out 1: one-cycle strobe; `distance` and `timeout` are updated in the same cycle.
- `timeout` out 1: 1 if the last measurement timed out. Updated with `valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
- `echo` passes through a 2-FF synchronizer, giving `echo_s`. Rising and falling edges are detected on `echo_s` against its previous value.
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: if `start`=1, go to TRIG. The period counter clears and starts counting.
- TRIG: `trig`=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. The wait counter clears.
- WAIT_RISE: wait for a rising edge of `echo_s`.
  - Edge seen: go to MEASURE. The cm counter and sub-counter clear.
  - Wait counter reaches TIMEOUT_CYCLES first: result is `distance`=MAX_CM, `timeout`=1; go to HOLDOFF.
  - An echo that is already high on entry is ignored until it falls and rises again.
- MEASURE: count each cycle with `echo_s`=1.
  - The sub-counter wraps at CYCLES_PER_CM−1 and increments the cm counter.
  - The cm counter saturates at MAX_CM and never wraps.
  - Falling edge of `echo_s`: result is the cm counter value, `timeout`=0 (floor division).
  - High time reaches TIMEOUT_CYCLES first: result is MAX_CM, `timeout`=1.
  - Either way, go to HOLDOFF.
- Result publication: on the transition into HOLDOFF, `distance` and `timeout` are registered and `valid` pulses for 1 cycle.
- HOLDOFF: stay until the period counter reaches PERIOD_CYCLES (measured from TRIG entry), then go to IDLE. `start` is ignored outside IDLE.
- A continuous `start`=1 therefore produces one measurement every PERIOD_CYCLES+1 clocks.
- Reset (asynchronous, at any time, including mid-measurement):
  - state returns to IDLE; all counters and synchronizer flops clear.
  - `trig`=0, `valid`=0, `distance`=0, `timeout`=0, `busy`=0.
  - No result is published for the aborted measurement.

## Timing
- `start` high at cycle N in IDLE → `trig` high cycles N+1..N+TRIG_CYCLES; `busy` high from N+1.
- `echo` rise to MEASURE entry: 3 cycles (2-FF synchronizer plus edge register).
- `echo` fall to `valid`: 3 cycles. End-of-echo latency is equal, so measured width equals the true width ±1 cycle.
- `valid` is never asserted in two consecutive cycles. `distance` is stable except in the `valid` cycle.
- If PERIOD_CYCLES is smaller than the actual elapsed time, HOLDOFF exits on the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: TRIG_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=400, PERIOD_CYCLES=600, MAX_CM=30.
- Reset: hold `rst_n`=0 with `echo` toggling → `trig`=0, `valid`=0, `distance`=0, `busy`=0. Release, no `start` → stays idle.
- Nominal: `start` pulse, echo high 125 cycles after `trig` falls → `trig` high exactly 4 cycles, `valid` once, `distance`=12, `timeout`=0.
- Boundaries: echo widths 9, 10, 309 and 350 cycles → `distance` 0, 1, 30, 30, all with `timeout`=0.
- No echo: `start`, `echo` held 0 → `valid` about 400 cycles after `trig` falls, `distance`=30, `timeout`=1. Stuck-high echo longer than 400 cycles → same result.
- Pacing: `start` held high → `trig` rising edges exactly 601 cycles apart. A `start` pulse during MEASURE is ignored (exactly one `valid`).
- Abort: assert `rst_n`=0 mid-MEASURE, release, then a new 55-cycle echo → no `valid` before the new trigger, then `distance`=5.
